seg_serial_driver: RTL and testbench

Serial driver for the board's 8-digit seven-segment display. It converts a 32-bit hex word, with per-digit decimal-point and blink controls, into a 64-bit active-low segment frame. On each request it shifts that frame into the external shift-register chain. It sits in the top level, fed by the score/health nibbles and a slow refresh tick (clkdiv[20]).

---
 rtl/seg_pkg.sv | 21 ++
 rtl/hex7seg_enc.sv | 14 +
 rtl/seg_serial_driver.sv | 133 +++++++++++++
 tb/tb_seg_serial_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment serial driver.
// Glyphs are active-low {g,f,e,d,c,b,a}; the DP bit is added by the encoder.
package seg_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  // Entry 15 is leftmost, so index 0 is the last element listed.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seg_state_e;

endpackage

// File: rtl/hex7seg_enc.sv
// One digit's active-low segment byte {dp,g,f,e,d,c,b,a}.
// i_dp=1 lights the point; i_blank forces every segment off.
module hex7seg_enc
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : {~i_dp, SEG_GLYPH[i_nibble]};

endmodule

// File: rtl/seg_serial_driver.sv
// Builds a 64-bit segment frame on a Start rising edge and shifts it MSB first
// into the external shift-register chain; SEG_PEN shows the latched frame when idle.
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int unsigned HALF_PER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        flash,
  input  logic [31:0] Hexs,
  input  logic [7:0]  point,
  input  logic [7:0]  LES,
  output logic        seg_clk,
  output logic        seg_clrn,
  output logic        seg_sout,
  output logic        SEG_PEN
);

  localparam int unsigned     CNT_W     = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PER - 1);

  seg_state_e            r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_frame, w_frame_nxt;
  logic [5:0]            r_bit_cnt, w_bit_nxt;
  logic [CNT_W-1:0]      r_half_cnt, w_half_nxt;
  logic                  r_phase, w_phase_nxt;     // 0 = low half, 1 = high half
  logic                  r_seg_clk, w_clk_nxt;
  logic                  r_sout, w_sout_nxt;
  logic                  r_pen, w_pen_nxt;
  logic                  r_clrn;
  logic                  r_start_q;

  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_start_edge;

  for (genvar i = 0; i < 8; i++) begin : g_digit
    hex7seg_enc u_enc (
      .i_nibble (Hexs[4*i +: 4]),
      .i_dp     (point[i]),
      .i_blank  (LES[i] & ~flash),
      .o_seg    (w_frame[8*i +: 8])
    );
  end

  assign w_start_edge = Start & ~r_start_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_bit_nxt   = r_bit_cnt;
    w_half_nxt  = r_half_cnt;
    w_phase_nxt = r_phase;
    w_clk_nxt   = r_seg_clk;
    w_sout_nxt  = r_sout;
    w_pen_nxt   = r_pen;

    unique case (r_state)
      IDLE: begin
        w_clk_nxt = 1'b0;
        if (w_start_edge) begin
          w_state_nxt = SHIFT;
          w_frame_nxt = w_frame;
          w_sout_nxt  = w_frame[FRAME_BITS-1];
          w_pen_nxt   = 1'b0;
          w_bit_nxt   = 6'(FRAME_BITS - 1);
          w_half_nxt  = '0;
          w_phase_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (r_half_cnt == HALF_LAST) begin
          w_half_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_clk_nxt   = 1'b1;
          end else if (r_bit_cnt == 6'd0) begin
            w_state_nxt = IDLE;
            w_clk_nxt   = 1'b0;
            w_pen_nxt   = 1'b1;
          end else begin
            // Shift after the high half so seg_sout stays put across the rise.
            w_bit_nxt   = r_bit_cnt - 6'd1;
            w_phase_nxt = 1'b0;
            w_clk_nxt   = 1'b0;
            w_frame_nxt = r_frame << 1;
            w_sout_nxt  = r_frame[FRAME_BITS-2];
          end
        end else begin
          w_half_nxt = r_half_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_bit_cnt  <= '0;
      r_half_cnt <= '0;
      r_phase    <= 1'b0;
      r_seg_clk  <= 1'b0;
      r_sout     <= 1'b1;
      r_pen      <= 1'b0;
      r_clrn     <= 1'b0;
      r_start_q  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_half_cnt <= w_half_nxt;
      r_phase    <= w_phase_nxt;
      r_seg_clk  <= w_clk_nxt;
      r_sout     <= w_sout_nxt;
      r_pen      <= w_pen_nxt;
      r_clrn     <= 1'b1;
      r_start_q  <= Start;
    end
  end

  assign seg_clk  = r_seg_clk;
  assign seg_clrn = r_clrn;
  assign seg_sout = r_sout;
  assign SEG_PEN  = r_pen;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Self-checking bench for seg_serial_driver (HALF_PER=1): frames are collected
// on seg_clk rises and compared with a digit-by-digit reference model.
module tb_seg_serial_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        flash;
  logic [31:0] Hexs;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic        seg_clk;
  logic        seg_clrn;
  logic        seg_sout;
  logic        SEG_PEN;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_serial_driver #(.HALF_PER(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .flash    (flash),
    .Hexs     (Hexs),
    .point    (point),
    .LES      (LES),
    .seg_clk  (seg_clk),
    .seg_clrn (seg_clrn),
    .seg_sout (seg_sout),
    .SEG_PEN  (SEG_PEN)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Display bytes for each hex value, point unlit.
  function automatic logic [7:0] glyph_byte(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [63:0] model_frame(input logic [31:0] hx, input logic [7:0] pt,
                                              input logic [7:0] les, input logic fl);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int d = 7; d >= 0; d--) begin
      if (les[d] && !fl) b = 8'hFF;
      else begin
        b = glyph_byte(4'((hx >> (4 * d)) & 32'hF));
        if (pt[d]) b = b - 8'h80;
      end
      f = (f << 8) | 64'(b);
    end
    return f;
  endfunction

  task automatic idle_quiet(input string tag, input int cycles, input logic exp_pen);
    int   rises;
    logic prev;
    rises = 0;
    prev  = seg_clk;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (seg_clk && !prev) rises++;
      prev = seg_clk;
    end
    check({tag, "/rises"}, 64'(rises), 64'd0);
    check({tag, "/pen"}, 64'(SEG_PEN), 64'(exp_pen));
  endtask

  // One transfer: edge at cycle n, samples at cycles n+1..n+140.
  task automatic run_xfer(input string tag, input logic [63:0] exp, input bit disturb,
                          input bit keep_start, input int abort_at);
    logic [63:0] bits;
    int          rises;
    int          pen_c;
    logic        prev;
    bits  = '0;
    rises = 0;
    pen_c = 0;
    @(negedge clk);
    Start = 1'b1;
    prev  = seg_clk;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 1)
        check({tag, "/first"}, {61'd0, SEG_PEN, seg_clk, seg_sout}, {61'd0, 1'b0, 1'b0, exp[63]});
      if (c == 2 && !keep_start) Start = 1'b0;
      if (disturb && c == 20) begin
        Start = 1'b1;
        Hexs  = $urandom;
        point = 8'($urandom);
        LES   = 8'($urandom);
        flash = ~flash;
      end
      if (seg_clk && !prev) begin
        bits = {bits[62:0], seg_sout};
        rises++;
      end
      prev = seg_clk;
      if (SEG_PEN && pen_c == 0) begin
        pen_c = c;
        check({tag, "/idle_clk"}, 64'(seg_clk), 64'd0);
      end
      if (abort_at > 0 && rises == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, "/abort_rst"}, {60'd0, seg_clk, seg_clrn, seg_sout, SEG_PEN}, 64'b0010);
        rst   = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        check({tag, "/abort_clrn"}, 64'(seg_clrn), 64'd1);
        return;
      end
    end
    check({tag, "/rises"}, 64'(rises), 64'd64);
    check({tag, "/frame"}, bits, exp);
    check({tag, "/pen_cycle"}, 64'(pen_c), 64'd129);
    Start = keep_start;
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    flash = 1'b1;
    Hexs  = '0;
    point = '0;
    LES   = '0;
    repeat (3) @(negedge clk);
    check("reset", {60'd0, seg_clk, seg_clrn, seg_sout, SEG_PEN}, 64'b0010);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_clrn", 64'(seg_clrn), 64'd1);
    idle_quiet("no_start", 20, 1'b0);

    Hexs = 32'h0000_0005; point = 8'b0100_0001; LES = 8'h00; flash = 1'b1;
    run_xfer("dp_digits", 64'hC040_C0C0_C0C0_C012, 1'b0, 1'b0, 0);

    Hexs = 32'h89AB_CDEF; point = 8'h00;
    run_xfer("hex_glyphs", 64'h8090_8883_C6A1_868E, 1'b0, 1'b0, 0);

    Hexs = 32'h0; LES = 8'h01; flash = 1'b0;
    run_xfer("blink_off", 64'hC0C0_C0C0_C0C0_C0FF, 1'b0, 1'b0, 0);
    flash = 1'b1;
    run_xfer("blink_on", 64'hC0C0_C0C0_C0C0_C0C0, 1'b0, 1'b0, 0);

    Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
    run_xfer("mid_shift", model_frame(Hexs, point, LES, flash), 1'b1, 1'b0, 0);
    run_xfer("after_mid", model_frame(Hexs, point, LES, flash), 1'b0, 1'b0, 0);

    Hexs = $urandom;
    run_xfer("held_start", model_frame(Hexs, point, LES, flash), 1'b0, 1'b1, 0);
    idle_quiet("held_quiet", 150, 1'b1);
    Start = 1'b0;

    run_xfer("abort", model_frame(Hexs, point, LES, flash), 1'b0, 1'b0, 34);
    Hexs = $urandom;
    run_xfer("after_abort", model_frame(Hexs, point, LES, flash), 1'b0, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      Hexs  = $urandom;
      point = 8'($urandom);
      LES   = 8'($urandom);
      flash = 1'($urandom);
      run_xfer("random", model_frame(Hexs, point, LES, flash), 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
